mux_reg_nch: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.

---
 rtl/muxreg_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mux_reg_nch.sv | 85 ++++++++
 tb/tb_mux_reg_nch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxreg_pkg.sv
// Shared types and helpers for the N-channel registered multiplexer.
// Holds the output-register state enum, the select-width helper and the mode encodings.
package muxreg_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin channel picker: searches upward from a rotating pointer, wrapping to 0.
// Only instantiated when MUXREG_ROUND_ROBIN_EN is defined.
module rr_arbiter
  import muxreg_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_any
);

  logic [SEL_W-1:0] ptr;

  // Scanning offsets from highest to lowest lets the closest request to ptr win.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[idx]) begin
        grant     = SEL_W'(idx);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/mux_reg_nch.sv
// N-channel, W-bit registered multiplexer with valid/ready handshake on both sides.
// Define MUXREG_ROUND_ROBIN_EN to make mode=1 select channels round-robin.
module mux_reg_nch
  import muxreg_pkg::*;
#(
  parameter  int WIDTH    = 3,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  state_t           state;
  logic             can_load;
  logic             transfer;
  logic             sel_ok;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic [WIDTH-1:0] sel_data;

  assign sel_ok   = (int'(select) < CHANNELS);
  assign can_load = (state == EMPTY) || out_ready;

`ifdef MUXREG_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_grant;
  logic             rr_any;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (in_valid),
    .advance   (transfer && (mode == MODE_RR)),
    .grant     (rr_grant),
    .grant_any (rr_any)
  );

  assign grant    = (mode == MODE_RR) ? rr_grant : select;
  assign grant_ok = (mode == MODE_RR) ? rr_any   : sel_ok;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant       = select;
  assign grant_ok    = sel_ok;
`endif

  // Out-of-range selects match no channel, so they naturally grant nothing.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_ok && (grant == SEL_W'(i))) begin
        in_ready[i] = can_load && in_valid[i];
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign transfer  = |in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      out_chan <= '0;
    end else if (transfer) begin
      state    <= FULL;
      out_data <= sel_data;
      out_chan <= grant;
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_reg_nch.sv
// Directed bench for mux_reg_nch: a 4-channel instance plus a 3-channel one for out-of-range selects.
// Round-robin vectors run only when MUXREG_ROUND_ROBIN_EN is defined.
module tb_mux_reg_nch;

  logic        clock;
  logic        reset;
  logic        mode;

  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  select;
  logic [2:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [8:0]  in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  select3;
  logic [2:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int checks   = 0;
  int failures = 0;

  mux_reg_nch #(.WIDTH(3), .CHANNELS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .mode      (mode),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_reg_nch #(.WIDTH(3), .CHANNELS(3)) dut3 (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .select    (select3),
    .mode      (mode),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [1:0] sel, input logic ordy);
    in_valid  = valid;
    select    = sel;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

`ifdef MUXREG_ROUND_ROBIN_EN
  int rrSeq [6] = '{0, 1, 2, 3, 0, 1};
`endif

  initial begin
    reset      = 1'b1;
    mode       = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    select     = '0;
    out_ready  = 1'b0;
    in_data3   = {3'd6, 3'd5, 3'd4};
    in_valid3  = 3'b111;
    select3    = 2'd3;
    out_ready3 = 1'b1;

    #12;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data",  32'(out_data),  32'd0);
    checkOutput("reset_chan",  32'(out_chan),  32'd0);
    step();
    reset = 1'b0;

    // External select, channel 2 carries 5
    in_data = {3'd0, 3'd5, 3'd0, 3'd0};
    applyStimulus(4'b0100, 2'd2, 1'b1);
    #1;
    checkOutput("sel2_ready", 32'(in_ready), 32'h4);
    step();
    checkOutput("sel2_data",  32'(out_data),  32'd5);
    checkOutput("sel2_chan",  32'(out_chan),  32'd2);
    checkOutput("sel2_valid", 32'(out_valid), 32'd1);

    // Backpressure holds the word and blocks grants
    in_data = {3'd0, 3'd3, 3'd0, 3'd0};
    applyStimulus(4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_ready", 32'(in_ready), 32'h0);
      step();
      checkOutput("stall_data", 32'(out_data), 32'd5);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_ready", 32'(in_ready), 32'h4);
    step();
    checkOutput("release_data",  32'(out_data),  32'd3);
    checkOutput("release_valid", 32'(out_valid), 32'd1);

    // Select changes while FULL only affect the next load
    in_data = {3'd4, 3'd3, 3'd2, 3'd1};
    applyStimulus(4'b1111, 2'd1, 1'b0);
    step();
    checkOutput("hold_chan", 32'(out_chan), 32'd2);
    checkOutput("hold_data", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    step();
    checkOutput("ch1_chan", 32'(out_chan), 32'd1);
    checkOutput("ch1_data", 32'(out_data), 32'd2);
    applyStimulus(4'b1111, 2'd3, 1'b0);
    step();
    checkOutput("hold2_chan", 32'(out_chan), 32'd1);
    out_ready = 1'b1;
    step();
    checkOutput("ch3_chan", 32'(out_chan), 32'd3);
    checkOutput("ch3_data", 32'(out_data), 32'd4);

    // Drain to EMPTY, then out_ready while EMPTY changes nothing
    applyStimulus(4'b0000, 2'd3, 1'b1);
    step();
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_data",  32'(out_data),  32'd4);

    // Asynchronous reset while FULL clears outputs before any edge
    in_data = {3'd0, 3'd5, 3'd0, 3'd0};
    applyStimulus(4'b0100, 2'd2, 1'b1);
    step();
    checkOutput("prereset_data", 32'(out_data), 32'd5);
    applyStimulus(4'b0000, 2'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_data",  32'(out_data),  32'd0);
    checkOutput("async_chan",  32'(out_chan),  32'd0);
    reset = 1'b0;
    step();

    // Three-channel instance: select 3 is out of range
    for (int i = 0; i < 3; i++) begin
      checkOutput("oor_ready", 32'(in_ready3),  32'h0);
      checkOutput("oor_valid", 32'(out_valid3), 32'd0);
      step();
    end
    select3 = 2'd2;
    #1;
    checkOutput("c3_ready", 32'(in_ready3), 32'h4);
    step();
    checkOutput("c3_data", 32'(out_data3), 32'd6);
    checkOutput("c3_chan", 32'(out_chan3), 32'd2);

`ifdef MUXREG_ROUND_ROBIN_EN
    // Round-robin over all-valid channels
    mode    = 1'b1;
    in_data = {3'd4, 3'd3, 3'd2, 3'd1};
    applyStimulus(4'b1111, 2'd0, 1'b1);
    pulseReset();
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("rr_ready", 32'(in_ready), 32'(1 << rrSeq[i]));
      step();
      checkOutput("rr_chan", 32'(out_chan), 32'(rrSeq[i]));
      checkOutput("rr_data", 32'(out_data), 32'(rrSeq[i] + 1));
    end

    // Pointer at 1, only channel 0 valid: wraps to 0, back-to-back
    pulseReset();
    applyStimulus(4'b0001, 2'd0, 1'b1);
    step();
    checkOutput("wrap0_chan", 32'(out_chan), 32'd0);
    #1;
    checkOutput("wrap_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("wrap_chan",  32'(out_chan),  32'd0);
    checkOutput("wrap_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0011;
    #1;
    checkOutput("ptr1_ready", 32'(in_ready), 32'h2);
    step();
    checkOutput("ptr1_chan", 32'(out_chan), 32'd1);
    mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
